// File: rtl/secded_pkg.sv
// Shared helpers for the extended-Hamming SECDED decoder and its future encoder:
// check-width sizing, codeword position mapping and the error classification type.
package secded_pkg;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_CORR,
      ERR_UNCORR
   } err_class_t;

   // Smallest r such that 2^r covers every codeword position plus the zero syndrome.
   function automatic int calc_r(input int data_w);
      int r;
      r = 1;
      while ((1 << r) < data_w + r + 1) r++;
      return r;
   endfunction

   function automatic logic is_pow2(input int x);
      return (x != 0) && ((x & (x - 1)) == 0);
   endfunction

   // Data bits skip the power-of-two slots, so data bit 0 lands on position 3.
   function automatic int data_pos(input int i);
      int pos;
      int cnt;
      pos = 3;
      cnt = 0;
      while (cnt < i || is_pow2(pos)) begin
         if (!is_pow2(pos)) cnt++;
         pos++;
      end
      return pos;
   endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational syndrome and overall-parity generator for an extended Hamming code.
// Shared by the decoder and the future encoder, so it stays free of any stream logic.
module secded_syndrome
   import secded_pkg::*;
#(
   parameter int DATA_W = 32,
   localparam int R = calc_r(DATA_W),
   localparam int CHK_W = R + 1
) (
   input  logic [DATA_W-1:0] data,
   input  logic [CHK_W-1:0]  chk,
   output logic [R-1:0]      syndrome,
   output logic              overall
);

   // Mask of the data bits whose codeword position has syndrome bit b set.
   function automatic logic [DATA_W-1:0] syn_mask(input int b);
      logic [DATA_W-1:0] m;
      int p;
      m = '0;
      for (int i = 0; i < DATA_W; i++) begin
         p = data_pos(i);
         m[i] = p[b];
      end
      return m;
   endfunction

   for (genvar b = 0; b < R; b++) begin : g_syn
      localparam logic [DATA_W-1:0] MASK = syn_mask(b);
      assign syndrome[b] = (^(data & MASK)) ^ chk[b];
   end

   assign overall = (^data) ^ (^chk);

endmodule

// File: rtl/secded_pipe_dec.sv
// Two-stage pipelined SECDED decoder with valid/ready streams and saturating
// error counters. Stage 1 holds the word with its syndrome, stage 2 the corrected result.
module secded_pipe_dec
   import secded_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W = 16,
   localparam int R = calc_r(DATA_W),
   localparam int CHK_W = R + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CHK_W-1:0]  in_chk,
   input  logic              in_chk_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err_corr,
   output logic              out_err_uncorr,
   output logic [R-1:0]      out_syndrome,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  cnt_corr,
   output logic [CNT_W-1:0]  cnt_uncorr
);

   localparam int NPOS = DATA_W + R;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [R-1:0]      syn;
   logic              ovr;

   logic              s1_valid, s1_ovr, s1_en;
   logic [DATA_W-1:0] s1_data;
   logic [R-1:0]      s1_syn;

   logic              s2_valid, s2_corr, s2_uncorr;
   logic [DATA_W-1:0] s2_data;
   logic [R-1:0]      s2_syn;

   logic              s1_load, s2_load, out_fire;
   logic [DATA_W-1:0] hit, fix;
   err_class_t        cls;

   secded_syndrome #(.DATA_W(DATA_W)) u_syn (
      .data     (in_data),
      .chk      (in_chk),
      .syndrome (syn),
      .overall  (ovr)
   );

   assign s2_load  = !s2_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;
   assign out_fire = s2_valid && out_ready;

   for (genvar g = 0; g < DATA_W; g++) begin : g_hit
      localparam int P = data_pos(g);
      assign hit[g] = (s1_syn == R'(P));
   end

   // A set overall mismatch means an odd error count; the syndrome then names the bit.
   always_comb begin
      cls = ERR_NONE;
      fix = '0;
      if (s1_en) begin
         if (s1_ovr) begin
            if (s1_syn == '0 || is_pow2(int'(s1_syn))) begin
               cls = ERR_CORR;
            end else if (int'(s1_syn) <= NPOS) begin
               cls = ERR_CORR;
               fix = hit;
            end else begin
               cls = ERR_UNCORR;
            end
         end else if (s1_syn != '0) begin
            cls = ERR_UNCORR;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_syn   <= '0;
         s1_ovr   <= 1'b0;
         s1_en    <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data <= in_data;
            s1_syn  <= syn;
            s1_ovr  <= ovr;
            s1_en   <= in_chk_en;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         s2_data   <= '0;
         s2_corr   <= 1'b0;
         s2_uncorr <= 1'b0;
         s2_syn    <= '0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data   <= s1_data ^ fix;
            s2_corr   <= (cls == ERR_CORR);
            s2_uncorr <= (cls == ERR_UNCORR);
            s2_syn    <= s1_en ? s1_syn : '0;
         end
      end
   end

   // Counting happens on delivery, and a clear in the same cycle drops that event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_corr   <= '0;
         cnt_uncorr <= '0;
      end else if (cnt_clr) begin
         cnt_corr   <= '0;
         cnt_uncorr <= '0;
      end else begin
         if (out_fire && s2_corr && cnt_corr != CNT_MAX)
            cnt_corr <= cnt_corr + CNT_W'(1);
         if (out_fire && s2_uncorr && cnt_uncorr != CNT_MAX)
            cnt_uncorr <= cnt_uncorr + CNT_W'(1);
      end
   end

   assign out_valid      = s2_valid;
   assign out_data       = s2_data;
   assign out_err_corr   = s2_corr;
   assign out_err_uncorr = s2_uncorr;
   assign out_syndrome   = s2_syn;

endmodule

// File: doc/secded_pipe_dec.md
# secded_pipe_dec

Parametrised, pipelined single-error-correct / double-error-detect decoder for DATA_W-bit words protected by an extended Hamming code. It corrects any single-bit error, flags uncorrectable errors, and keeps saturating error counters. Input and output use valid/ready streams. It sits between a protected storage or link and its consumer, and is the registered, width-generic successor of the fixed 32-bit combinational corrector.

## Interface
- DATA_W, default 32: data bits per word; must be ≥ 4.
- CNT_W, default 16: width of each error counter.
- R (derived): smallest r with 2^r ≥ DATA_W + r + 1.
- CHK_W (derived): R + 1. For DATA_W = 32, CHK_W = 7.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  decoder can accept a word this cycle.
- in_data  in  DATA_W  received data bits.
- in_chk  in  CHK_W  received check bits. Bits [R-1:0] are the Hamming bits; bit [R] is overall parity.
- in_chk_en  in  1  correction enable; travels with the word.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  DATA_W  corrected data, or raw data when uncorrectable or disabled.
- out_err_corr  out  1  a single error was corrected (in data or check bits).
- out_err_uncorr  out  1  an uncorrectable error was detected.
- out_syndrome  out  R  Hamming syndrome of the word.
- cnt_clr  in  1  synchronous clear of both counters.
- cnt_corr  out  CNT_W  count of delivered words with out_err_corr set; saturating.
- cnt_uncorr  out  CNT_W  count of delivered words with out_err_uncorr set; saturating.

## Operation
**Codeword layout**
- Hamming positions run 1..DATA_W+R.
- in_chk[i] sits at position 2^i.
- Data bits fill the non-power-of-two positions in ascending order, so in_data[0] is at position 3.

**Decode**
- Syndrome s = XOR of the position indices of all set codeword bits (data and Hamming check bits).
- Overall mismatch o = XOR of all data bits and all CHK_W check bits.

**Classification** (applies only when in_chk_en = 1)
- s = 0, o = 0: no error.
- o = 1, s = 0: error in in_chk[R]. Set corr; data unchanged.
- o = 1, s a power of two: error in a Hamming check bit. Set corr; data unchanged.
- o = 1, s a data position: flip that data bit. Set corr.
- o = 1, s > DATA_W+R: set uncorr; pass raw data.
- o = 0, s ≠ 0: double error. Set uncorr; pass raw data.

**Correction disabled** (in_chk_en = 0)
- Data passes raw.
- Both flags are 0 and out_syndrome is 0.

**Error counters**
- Each counter increments by 1 on an output handshake (out_valid & out_ready) when its flag is set.
- Each saturates at 2^CNT_W − 1.
- If cnt_clr is asserted in the same cycle as an increment, clear wins and that event is not counted.

## Timing
- Two register stages:
  - S1 registers the input word, s and o.
  - S2 registers the corrected data and flags.
- Latency is 2 cycles from the input handshake to out_valid, with no backpressure. Throughput is one word per cycle.
- Stall rule: S2 loads when it is empty or out_ready = 1. S1 loads when it is empty or S2 loads. in_ready = S1 empty or S2 loads.
- in_ready is combinational from out_ready. Two words can be buffered internally.
- While out_valid = 1 and out_ready = 0, the output word and flags hold stable.
- On reset: in_ready = 1 after release; out_valid = 0; out_data, flags and syndrome = 0; both counters = 0.
- Reset mid-stream discards all in-flight words. No partial output appears after reset.
- A handshake on the rising edge that coincides with reset release is ignored.

## Structure
- Package secded_pkg holds:
  - function calc_r(DATA_W);
  - function data_pos(i), returning the Hamming position of data bit i;
  - function is_pow2;
  - enum err_class_t {ERR_NONE, ERR_CORR, ERR_UNCORR}.
- Sub-module secded_syndrome is the combinational s/o generator. It is parametrised by DATA_W and is reused by the future encoder.
- The top level holds the stage registers, the handshake logic, the correction mux and the counters.

## Test plan
- Clean word, DATA_W = 32: 0xDEADBEEF with bench-encoded check bits, in_chk_en = 1 → out 0xDEADBEEF two cycles later; corr = 0, uncorr = 0, syndrome 0, counters 0.
- Single data flip, in_data bit 5 inverted (0xDEADBECF) → out 0xDEADBEEF; corr = 1; syndrome = data_pos(5) = 10; cnt_corr = 1 after the handshake.
- in_chk[6] flipped → data unchanged, corr = 1, syndrome 0.
- Data bits 0 and 1 flipped → out raw 0xDEADBEEC, uncorr = 1, cnt_uncorr = 1.
- Same double error with in_chk_en = 0 → flags 0 and counters unchanged.
- Backpressure: hold out_ready = 0 and offer 3 words → in_ready drops after 2 accepted. Release out_ready → all 3 words delivered in order with no loss or duplication; output stable while stalled.
- CNT_W = 2: 5 correctable words → cnt_corr = 3 (saturated). cnt_clr together with a 6th correctable handshake → cnt_corr = 0.
- Assert rst with 2 words in flight → out_valid falls immediately, counters 0; no stale word appears after release.
